// File: rtl/sync_fifo_flex_pkg.sv
// rtl/sync_fifo_flex_pkg.sv - shared constants and status/error types for sync_fifo_flex
package sync_fifo_flex_pkg;

   localparam int RD_LAT_SHOWAHEAD = 0;
   localparam int RD_LAT_REG       = 1;

   typedef struct packed {
      logic full;
      logic almost_full;
      logic empty;
      logic almost_empty;
   } fifo_status_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

endpackage

// File: rtl/sync_fifo_flex_if.sv
// rtl/sync_fifo_flex_if.sv - producer/consumer/control bundle for sync_fifo_flex
interface sync_fifo_flex_if
   import sync_fifo_flex_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 64
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  push_req_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  push_ack_out;
   logic                  pop_req_in;
   logic                  pop_ack_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rvalid_out;
   logic                  flush_in;
   logic [CNT_W-1:0]      ae_thresh_in;
   logic [CNT_W-1:0]      af_thresh_in;
   logic                  full_out;
   logic                  almost_full_out;
   logic                  empty_out;
   logic                  almost_empty_out;
   logic [CNT_W-1:0]      level_out;
   logic                  err_clr_in;
   logic                  overflow_out;
   logic                  underflow_out;

   modport master (
      output push_req_in, data_in, pop_req_in, flush_in,
             ae_thresh_in, af_thresh_in, err_clr_in,
      input  push_ack_out, pop_ack_out, data_out, rvalid_out,
             full_out, almost_full_out, empty_out, almost_empty_out,
             level_out, overflow_out, underflow_out
   );

   modport slave (
      input  push_req_in, data_in, pop_req_in, flush_in,
             ae_thresh_in, af_thresh_in, err_clr_in,
      output push_ack_out, pop_ack_out, data_out, rvalid_out,
             full_out, almost_full_out, empty_out, almost_empty_out,
             level_out, overflow_out, underflow_out
   );

endinterface

// File: rtl/sync_fifo_flex_mem.sv
// rtl/sync_fifo_flex_mem.sv - 1-write/1-read storage, no reset so a RAM macro can replace it
module fifo_mem_1w1r #(
   parameter int  DATA_WIDTH = 16,
   parameter int  DEPTH      = 64,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with any depth, selectable read latency and sticky errors
module sync_fifo_flex
   import sync_fifo_flex_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int DEPTH        = 64,
   parameter int READ_LATENCY = RD_LAT_SHOWAHEAD
) (
   input logic             clk,
   input logic             rstn,
   sync_fifo_flex_if.slave bus
);
   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]      wrpnt;
   logic [PTR_W-1:0]      rdpnt;
   logic [CNT_W-1:0]      cnt;
   fifo_err_t             err_q;
   fifo_status_t          status;
   logic                  push_ack;
   logic                  pop_ack;
   logic [DATA_WIDTH-1:0] rd_data;

   always_comb begin
      status.empty        = (cnt == '0);
      status.full         = (cnt == FULL_CNT);
      status.almost_full  = (cnt >= bus.af_thresh_in);
      status.almost_empty = (cnt <= bus.ae_thresh_in);
   end

   // a full FIFO still takes a push when the same cycle frees a slot
   assign pop_ack  = bus.pop_req_in & ~status.empty & ~bus.flush_in;
   assign push_ack = bus.push_req_in & (~status.full | pop_ack) & ~bus.flush_in;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wrpnt <= '0;
         rdpnt <= '0;
         cnt   <= '0;
      end else if (bus.flush_in) begin
         wrpnt <= '0;
         rdpnt <= '0;
         cnt   <= '0;
      end else begin
         if (push_ack) wrpnt <= (wrpnt == LAST_PTR) ? '0 : wrpnt + 1'b1;
         if (pop_ack)  rdpnt <= (rdpnt == LAST_PTR) ? '0 : rdpnt + 1'b1;
         if (push_ack && !pop_ack)      cnt <= cnt + 1'b1;
         else if (pop_ack && !push_ack) cnt <= cnt - 1'b1;
      end
   end

   // a fresh rejection in the clearing cycle keeps the flag set
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= '0;
      end else begin
         err_q.overflow  <= (err_q.overflow & ~bus.err_clr_in)
                          | (bus.push_req_in & ~push_ack & ~bus.flush_in);
         err_q.underflow <= (err_q.underflow & ~bus.err_clr_in)
                          | (bus.pop_req_in & ~pop_ack & ~bus.flush_in);
      end
   end

   fifo_mem_1w1r #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_ack),
      .waddr (wrpnt),
      .wdata (bus.data_in),
      .raddr (rdpnt),
      .rdata (rd_data)
   );

   generate
      if (READ_LATENCY == RD_LAT_REG) begin : g_reg_read
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  rvalid_q;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               dout_q   <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= pop_ack;
               if (pop_ack) dout_q <= rd_data;
            end
         end

         assign bus.data_out   = dout_q;
         assign bus.rvalid_out = rvalid_q;
      end else begin : g_showahead_read
         assign bus.data_out   = rd_data;
         assign bus.rvalid_out = ~status.empty;
      end
   endgenerate

   assign bus.push_ack_out     = push_ack;
   assign bus.pop_ack_out      = pop_ack;
   assign bus.full_out         = status.full;
   assign bus.almost_full_out  = status.almost_full;
   assign bus.empty_out        = status.empty;
   assign bus.almost_empty_out = status.almost_empty;
   assign bus.level_out        = cnt;
   assign bus.overflow_out     = err_q.overflow;
   assign bus.underflow_out    = err_q.underflow;

endmodule
